// File: rtl/divider_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : divider_unit_pkg
//  Description : Shared constants for the iterative divider: default operand
//                width, ALUControl op codes and FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package divider_unit_pkg;

    localparam int c_XLEN_DEFAULT = 32;

    // Divider ops extend the 5-bit ALU encoding; bit 1 selects remainder,
    // bit 0 selects unsigned.
    localparam logic [4:0] c_OP_DIV  = 5'b10000;
    localparam logic [4:0] c_OP_DIVU = 5'b10001;
    localparam logic [4:0] c_OP_REM  = 5'b10010;
    localparam logic [4:0] c_OP_REMU = 5'b10011;

    localparam int         c_ST_W    = 2;
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CALC = 2'd1;
    localparam logic [1:0] c_ST_FIX  = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

endpackage : divider_unit_pkg
`default_nettype wire

// File: rtl/divider_unit_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : divider_unit_div_step
//  Description : One combinational restoring-division iteration. The dividend
//                shifts out of the MSB of i_quo into the partial remainder
//                while the new quotient bit shifts into its LSB.
//  Revision    : 1.0 - initial release
// ============================================================================
module divider_unit_div_step
    import divider_unit_pkg::*;
#(
    parameter int XLEN = c_XLEN_DEFAULT
) (
    input  logic [XLEN:0]   i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_div,
    output logic [XLEN:0]   o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN+1:0] w_shift;
    logic [XLEN+1:0] w_diff;
    logic            w_neg;

    // Trial subtraction one bit wider than the remainder so the borrow is visible.
    always_comb begin
        w_shift = {i_rem, i_quo[XLEN-1]};
        w_diff  = w_shift - {2'b00, i_div};
        w_neg   = w_diff[XLEN+1];
        o_rem   = w_neg ? w_shift[XLEN:0] : w_diff[XLEN:0];
        o_quo   = {i_quo[XLEN-2:0], ~w_neg};
    end

endmodule : divider_unit_div_step
`default_nettype wire

// File: rtl/divider_unit.sv
`default_nettype none
// ============================================================================
//  Module      : divider_unit
//  Description : Multi-cycle restoring divider for DIV/DIVU/REM/REMU with
//                valid/ready handshakes, divide-by-zero and signed-overflow
//                short cuts, flush and synchronous reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module divider_unit
    import divider_unit_pkg::*;
#(
    parameter int XLEN           = c_XLEN_DEFAULT,
    parameter int ITER_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [4:0]      ALUControl,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] Result,
    output logic            DivZero,
    output logic            OverFlow
);

    localparam int              c_STEPS = XLEN / ITER_PER_CYCLE;
    localparam int              c_CNT_W = $clog2(c_STEPS) + 1;
    localparam logic [XLEN-1:0] c_ONES  = '1;
    localparam logic [XLEN-1:0] c_MIN   = {1'b1, {(XLEN-1){1'b0}}};

    logic [c_ST_W-1:0]  r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [XLEN:0]      r_rem;
    logic [XLEN-1:0]    r_quo;
    logic [XLEN-1:0]    r_div;
    logic               r_is_rem;
    logic               r_qneg;
    logic               r_rneg;
    logic [XLEN-1:0]    r_result;
    logic               r_divzero;
    logic               r_overflow;

    logic               w_op_ok;
    logic               w_is_rem;
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [XLEN-1:0]    w_a_mag;
    logic [XLEN-1:0]    w_b_mag;
    logic [XLEN-1:0]    w_q_fix;
    logic [XLEN-1:0]    w_r_fix;
    logic [XLEN-1:0]    w_fix_result;

    logic [XLEN:0]      w_rem_chain [0:ITER_PER_CYCLE];
    logic [XLEN-1:0]    w_quo_chain [0:ITER_PER_CYCLE];

    // Request decode and operand magnitudes, evaluated only while IDLE matters.
    always_comb begin
        w_op_ok  = (ALUControl == c_OP_DIV)  || (ALUControl == c_OP_DIVU) ||
                   (ALUControl == c_OP_REM)  || (ALUControl == c_OP_REMU);
        w_is_rem = ALUControl[1];
        w_signed = ~ALUControl[0];
        w_a_neg  = w_signed & A[XLEN-1];
        w_b_neg  = w_signed & B[XLEN-1];
        w_a_mag  = w_a_neg ? -A : A;
        w_b_mag  = w_b_neg ? -B : B;
    end

    // Sign correction applied once the unsigned iteration has finished.
    always_comb begin
        w_q_fix      = r_qneg ? -r_quo : r_quo;
        w_r_fix      = r_rneg ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];
        w_fix_result = r_is_rem ? w_r_fix : w_q_fix;
    end

    assign w_rem_chain[0] = r_rem;
    assign w_quo_chain[0] = r_quo;

    genvar gi;
    generate
        for (gi = 0; gi < ITER_PER_CYCLE; gi++) begin : g_step
            divider_unit_div_step #(
                .XLEN (XLEN)
            ) u_step (
                .i_rem (w_rem_chain[gi]),
                .i_quo (w_quo_chain[gi]),
                .i_div (r_div),
                .o_rem (w_rem_chain[gi+1]),
                .o_quo (w_quo_chain[gi+1])
            );
        end
    endgenerate

    // Control FSM plus operand/iteration/result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_div      <= '0;
            r_is_rem   <= 1'b0;
            r_qneg     <= 1'b0;
            r_rneg     <= 1'b0;
            r_result   <= '0;
            r_divzero  <= 1'b0;
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_result   <= '0;
            r_divzero  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid) begin
                        if (!w_op_ok) begin
                            r_state    <= c_ST_DONE;
                            r_result   <= '0;
                            r_divzero  <= 1'b0;
                            r_overflow <= 1'b0;
                        end else if (B == '0) begin
                            r_state    <= c_ST_DONE;
                            r_result   <= w_is_rem ? A : c_ONES;
                            r_divzero  <= 1'b1;
                            r_overflow <= 1'b0;
                        end else if (w_signed && (A == c_MIN) && (B == c_ONES)) begin
                            r_state    <= c_ST_DONE;
                            r_result   <= w_is_rem ? '0 : c_MIN;
                            r_divzero  <= 1'b0;
                            r_overflow <= 1'b1;
                        end else begin
                            r_state  <= c_ST_CALC;
                            r_cnt    <= '0;
                            r_rem    <= '0;
                            r_quo    <= w_a_mag;
                            r_div    <= w_b_mag;
                            r_is_rem <= w_is_rem;
                            r_qneg   <= w_a_neg ^ w_b_neg;
                            r_rneg   <= w_a_neg;
                        end
                    end
                end
                c_ST_CALC: begin
                    r_rem <= w_rem_chain[ITER_PER_CYCLE];
                    r_quo <= w_quo_chain[ITER_PER_CYCLE];
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    if (r_cnt == c_CNT_W'(c_STEPS - 1)) begin
                        r_state <= c_ST_FIX;
                    end
                end
                c_ST_FIX: begin
                    r_result <= w_fix_result;
                    r_state  <= c_ST_DONE;
                end
                c_ST_DONE: begin
                    if (out_ready) begin
                        r_state    <= c_ST_IDLE;
                        r_divzero  <= 1'b0;
                        r_overflow <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == c_ST_IDLE);
    assign out_valid = (r_state == c_ST_DONE);
    assign Result    = r_result;
    assign DivZero   = r_divzero;
    assign OverFlow  = r_overflow;

endmodule : divider_unit
`default_nettype wire

// File: tb/tb_divider_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_divider_unit
//  Description : Self-checking bench for divider_unit: directed cases,
//                randomized ops against an arithmetic reference model,
//                output hold, abort by reset/flush and busy-input rejection.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_divider_unit;

    localparam logic [4:0] c_DIV  = 5'b10000;
    localparam logic [4:0] c_DIVU = 5'b10001;
    localparam logic [4:0] c_REM  = 5'b10010;
    localparam logic [4:0] c_REMU = 5'b10011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r_in_valid = 1'b0;
    logic        w_in_ready;
    logic [31:0] r_a = '0;
    logic [31:0] r_b = '0;
    logic [4:0]  r_op = '0;
    logic        r_flush = 1'b0;
    logic        w_out_valid;
    logic        r_out_ready = 1'b0;
    logic [31:0] w_result;
    logic        w_divzero;
    logic        w_overflow;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    divider_unit #(
        .XLEN           (32),
        .ITER_PER_CYCLE (1)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (r_in_valid),
        .in_ready   (w_in_ready),
        .A          (r_a),
        .B          (r_b),
        .ALUControl (r_op),
        .flush      (r_flush),
        .out_valid  (w_out_valid),
        .out_ready  (r_out_ready),
        .Result     (w_result),
        .DivZero    (w_divzero),
        .OverFlow   (w_overflow)
    );

    // Reference: RISC-V style division rules expressed with plain arithmetic.
    task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic dz, output logic ov,
                         output int lat);
        bit is_signed;
        bit is_rem;
        is_signed = (op == c_DIV) || (op == c_REM);
        is_rem    = (op == c_REM) || (op == c_REMU);
        dz = 1'b0;
        ov = 1'b0;
        if (!(op == c_DIV || op == c_DIVU || op == c_REM || op == c_REMU)) begin
            res = 32'd0;
            lat = 1;
        end else if (b == 32'd0) begin
            res = is_rem ? a : 32'hFFFF_FFFF;
            dz  = 1'b1;
            lat = 1;
        end else if (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            res = is_rem ? 32'd0 : 32'h8000_0000;
            ov  = 1'b1;
            lat = 1;
        end else begin
            if (is_signed) res = is_rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
            else           res = is_rem ? (a % b) : (a / b);
            lat = 34;
        end
    endtask

    // Issue one request, wait (bounded) for the result, then consume it.
    // lat counts edges from and including the accept edge.
    task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit noisy, output logic [31:0] res, output logic dz,
                         output logic ov, output int lat, output bit bad);
        bad = 1'b0;
        @(negedge clk);
        r_op = op; r_a = a; r_b = b; r_in_valid = 1'b1; r_out_ready = 1'b0;
        if (w_in_ready !== 1'b1) bad = 1'b1;
        @(posedge clk); #1;
        r_in_valid = noisy;
        r_a = $urandom; r_b = $urandom; r_op = 5'($urandom_range(16, 19));
        lat = 1;
        while (w_out_valid !== 1'b1 && lat < 100) begin
            if (w_in_ready !== 1'b0 || w_divzero !== 1'b0 || w_overflow !== 1'b0) bad = 1'b1;
            if (noisy) begin r_a = $urandom; r_b = $urandom; end
            @(posedge clk); #1;
            lat++;
        end
        res = w_result; dz = w_divzero; ov = w_overflow;
        r_in_valid = 1'b0; r_out_ready = 1'b1;
        @(posedge clk); #1;
        r_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({w_in_ready, w_out_valid, w_result, w_divzero, w_overflow} !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset: got rdy=%0b vld=%0b res=%h dz=%0b ov=%0b, want rdy=1 vld=0 res=0 dz=0 ov=0",
                     w_in_ready, w_out_valid, w_result, w_divzero, w_overflow);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [4:0]  ops [8] = '{c_DIVU, c_REMU, c_DIV, c_REM, c_DIV, c_REM, c_DIV, c_REM};
        logic [31:0] as  [8] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                 32'd12345, 32'd12345, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [8] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] er  [8] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                 32'hFFFF_FFFF, 32'd12345, 32'h8000_0000, 32'd0};
        logic        edz [8] = '{0, 0, 0, 0, 1, 1, 0, 0};
        logic        eov [8] = '{0, 0, 0, 0, 0, 0, 1, 1};
        int          elat[8] = '{34, 34, 34, 34, 1, 1, 1, 1};
        logic [31:0] res;
        logic        dz, ov;
        int          lat;
        bit          bad;
        for (int i = 0; i < 8; i++) begin
            do_op(ops[i], as[i], bs[i], 1'b0, res, dz, ov, lat, bad);
            n_vec++;
            if ({res, dz, ov} !== {er[i], edz[i], eov[i]} || lat != elat[i]) begin
                n_err++;
                $display("FAIL directed[%0d]: got res=%h dz=%0b ov=%0b lat=%0d, want res=%h dz=%0b ov=%0b lat=%0d",
                         i, res, dz, ov, lat, er[i], edz[i], eov[i], elat[i]);
            end
        end
    endtask

    task automatic test_random(input int count, input bit noisy);
        logic [4:0]  op;
        logic [31:0] a, b, res, eres;
        logic        dz, ov, edz, eov;
        int          lat, elat, sel;
        bit          bad;
        for (int i = 0; i < count; i++) begin
            sel = $urandom_range(0, 19);
            op  = (sel == 0) ? 5'($urandom_range(0, 15)) : 5'($urandom_range(16, 19));
            a   = $urandom;
            b   = (sel % 3 == 1) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (sel == 2) b = 32'd0;
            if (sel == 3) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (sel == 4) begin a = 32'($urandom_range(0, 50)); b = 32'hFFFF_FFFF; end
            model(op, a, b, eres, edz, eov, elat);
            do_op(op, a, b, noisy, res, dz, ov, lat, bad);
            n_vec++;
            if ({res, dz, ov} !== {eres, edz, eov} || lat != elat || bad) begin
                n_err++;
                $display("FAIL random op=%b a=%h b=%h: got res=%h dz=%0b ov=%0b lat=%0d busy_err=%0b, want res=%h dz=%0b ov=%0b lat=%0d busy_err=0",
                         op, a, b, res, dz, ov, lat, bad, eres, edz, eov, elat);
            end
        end
    endtask

    task automatic test_hold();
        int waited;
        @(negedge clk);
        r_op = c_DIVU; r_a = 32'd83810205; r_b = 32'd6789; r_in_valid = 1'b1; r_out_ready = 1'b0;
        @(posedge clk); #1;
        r_in_valid = 1'b0;
        waited = 0;
        while (w_out_valid !== 1'b1 && waited < 100) begin
            @(posedge clk); #1; waited++;
        end
        n_vec++;
        if (waited != 33) begin
            n_err++;
            $display("FAIL hold_latency: got %0d extra edges, want 33", waited);
        end
        for (int i = 0; i < 5; i++) begin
            r_in_valid = 1'b1;
            n_vec++;
            if ({w_out_valid, w_in_ready, w_result, w_divzero, w_overflow} !== {1'b1, 1'b0, 32'd12345, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL hold[%0d]: got vld=%0b rdy=%0b res=%h dz=%0b ov=%0b, want vld=1 rdy=0 res=%h dz=0 ov=0",
                         i, w_out_valid, w_in_ready, w_result, w_divzero, w_overflow, 32'd12345);
            end
            @(posedge clk); #1;
        end
        r_in_valid = 1'b0;
        r_out_ready = 1'b1;
        #1;
        n_vec++;
        if (w_in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL done_ready: got in_ready=%0b with out_ready=1 in DONE, want 0", w_in_ready);
        end
        @(posedge clk); #1;
        r_out_ready = 1'b0;
        n_vec++;
        if ({w_in_ready, w_out_valid, w_divzero, w_overflow} !== 4'b1000) begin
            n_err++;
            $display("FAIL hold_release: got rdy=%0b vld=%0b dz=%0b ov=%0b, want rdy=1 vld=0 dz=0 ov=0",
                     w_in_ready, w_out_valid, w_divzero, w_overflow);
        end
    endtask

    task automatic test_abort();
        logic [31:0] res;
        logic        dz, ov;
        int          lat;
        bit          bad;
        bit          seen;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            r_op = c_DIVU; r_a = 32'd1000000; r_b = 32'd3; r_in_valid = 1'b1;
            @(posedge clk); #1;
            r_in_valid = 1'b0;
            repeat (9) @(posedge clk);
            #1;
            if (k == 0) rst = 1'b1; else r_flush = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0; r_flush = 1'b0;
            n_vec++;
            if ({w_in_ready, w_out_valid, w_divzero, w_overflow} !== 4'b1000) begin
                n_err++;
                $display("FAIL abort_%s: got rdy=%0b vld=%0b dz=%0b ov=%0b, want rdy=1 vld=0 dz=0 ov=0",
                         k == 0 ? "rst" : "flush", w_in_ready, w_out_valid, w_divzero, w_overflow);
            end
            seen = 1'b0;
            repeat (40) begin @(posedge clk); #1; if (w_out_valid !== 1'b0) seen = 1'b1; end
            n_vec++;
            if (seen) begin
                n_err++;
                $display("FAIL abort_stale_%0d: got out_valid=1 after abort, want 0", k);
            end
        end
        // Flush drops a finished result even while the consumer is stalled.
        @(negedge clk);
        r_op = c_REM; r_a = 32'd5; r_b = 32'd0; r_in_valid = 1'b1;
        @(posedge clk); #1;
        r_in_valid = 1'b0; r_flush = 1'b1;
        @(posedge clk); #1;
        r_flush = 1'b0;
        n_vec++;
        if ({w_in_ready, w_out_valid, w_divzero} !== 3'b100) begin
            n_err++;
            $display("FAIL flush_done: got rdy=%0b vld=%0b dz=%0b, want rdy=1 vld=0 dz=0",
                     w_in_ready, w_out_valid, w_divzero);
        end
        // Flush beats a simultaneous accept.
        @(negedge clk);
        r_op = c_DIV; r_a = 32'd9; r_b = 32'd0; r_in_valid = 1'b1; r_flush = 1'b1;
        @(posedge clk); #1;
        r_in_valid = 1'b0; r_flush = 1'b0;
        n_vec++;
        if ({w_in_ready, w_out_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL flush_vs_accept: got rdy=%0b vld=%0b, want rdy=1 vld=0", w_in_ready, w_out_valid);
        end
        do_op(c_DIVU, 32'd83810205, 32'd6789, 1'b0, res, dz, ov, lat, bad);
        n_vec++;
        if ({res, dz, ov} !== {32'd12345, 1'b0, 1'b0} || lat != 34 || bad) begin
            n_err++;
            $display("FAIL after_abort: got res=%h dz=%0b ov=%0b lat=%0d busy_err=%0b, want res=%h dz=0 ov=0 lat=34 busy_err=0",
                     res, dz, ov, lat, bad, 32'd12345);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random(40, 1'b0);
        test_random(15, 1'b1);
        test_hold();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_divider_unit
`default_nettype wire

// File: doc/divider_unit.md
DIVIDER_UNIT -- requirements
Module: divider_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; only 32 is required to be supported.
REQ-002 Parameter ITER_PER_CYCLE, default 1, quotient bits resolved per CALC cycle; only 1 is required.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  unit can accept a request this cycle.
REQ-007 A  input  XLEN  dividend.
REQ-008 B  input  XLEN  divisor.
REQ-009 ALUControl  input  5  op select: 10000 DIV, 10001 DIVU, 10010 REM, 10011 REMU (extends ALU 5-bit encoding).
REQ-010 flush  input  1  pipeline flush, aborts any operation.
REQ-011 out_valid  output  1  Result valid.
REQ-012 out_ready  input  1  consumer takes Result this cycle.
REQ-013 Result  output  XLEN  quotient or remainder per op.
REQ-014 DivZero  output  1  divisor was zero, valid with out_valid.
REQ-015 OverFlow  output  1  signed overflow (-2^31 / -1), valid with out_valid.

Function
REQ-016 FSM states IDLE, CALC, FIX, DONE; in_ready SHALL be 1 only in IDLE.
REQ-017 Accept = in_valid & in_ready; on accept, A, B and op SHALL be latched; later input changes have no effect.
REQ-018 Accepted op code outside 10000-10011 SHALL go to DONE with Result 0, DivZero 0, OverFlow 0.
REQ-019 Accepted B==0: next state DONE; quotient all-ones (0xFFFFFFFF), remainder = A; DivZero=1.
REQ-020 Accepted signed op with A==0x80000000, B==0xFFFFFFFF: next state DONE; DIV Result 0x80000000, REM Result 0; OverFlow=1.
REQ-021 Otherwise: signed ops convert operands to magnitudes, record quotient sign (A[31]^B[31]) and remainder sign (A[31]); enter CALC with counter 0.
REQ-022 CALC: one restoring shift-subtract step per edge, 33-bit partial remainder; after exactly 32 CALC edges go to FIX.
REQ-023 FIX: apply sign correction (two's complement negate) and select quotient/remainder; next edge to DONE.
REQ-024 Normal latency: out_valid rises 34 edges after the accept edge; special cases (REQ-018..020) 1 edge.
REQ-025 Remainder sign SHALL equal dividend sign; |remainder| < |divisor|; A == Q*B + R for all non-special cases.
REQ-026 DONE: out_valid=1, Result/flags held stable until out_ready=1; edge with out_ready=1 returns to IDLE.
REQ-027 No back-to-back acceptance: in_ready stays 0 in the DONE cycle even when out_ready=1.
REQ-028 flush=1 in any state SHALL force IDLE on the next edge, drop the result, clear out_valid; flush has priority over accept and out_ready.
REQ-029 in_valid while not in IDLE SHALL be ignored (no queueing).
REQ-030 DivZero and OverFlow SHALL be 0 whenever out_valid=0.

Reset
REQ-031 rst=1 at an edge SHALL force IDLE in any state, including mid-CALC, and has priority over flush.
REQ-032 Reset values: in_ready=1, out_valid=0, Result=0, DivZero=0, OverFlow=0, counter=0, partial remainder=0.

Structure
REQ-033 Shared package holds ALUControl op constants (DIV/DIVU/REM/REMU), FSM state encoding, XLEN default.
REQ-034 One sub-module, div_step: combinational single restoring iteration (partial remainder, quotient bit in; updated values out).
REQ-035 Operand registers, counter and FSM live in divider_unit; no multi-cycle combinational paths.

Verification
REQ-036 DIVU A=100, B=7 -> after 34 edges Result=14, DivZero=0, OverFlow=0; REMU same operands -> Result=2.
REQ-037 DIV A=-7 (0xFFFFFFF9), B=2 -> Result=0xFFFFFFFD (-3); REM -> Result=0xFFFFFFFF (-1).
REQ-038 DIV A=12345, B=0 -> 1 edge later Result=0xFFFFFFFF, DivZero=1; REM -> Result=12345, DivZero=1.
REQ-039 DIV A=0x80000000, B=0xFFFFFFFF -> 1 edge later Result=0x80000000, OverFlow=1; REM -> Result=0.
REQ-040 DIVU A=83810205, B=6789 with out_ready=0 for 5 cycles after out_valid -> Result=12345 held stable, in_ready=0, then IDLE after out_ready.
REQ-041 Start DIVU, assert rst at CALC edge 10 -> next cycle in_ready=1, out_valid=0; repeat with flush -> same; new request then completes correctly.
